multicycle_sequencer: RTL and testbench

- Parametrised multicycle control unit that drives the control inputs of the RV64I datapath.
- Adds what the current flow lacks:
  - valid/ready memory handshake with wait-state tolerance and timeout;
  - run/idle mode;
  - illegal-opcode trap;
  - retired-instruction counter.
- Sits between the datapath (opcode in, strobes out) and the shared instruction/data memory port.

---
 rtl/multicycle_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control unit for the RV64I datapath: sequences FETCH/DECODE/
// EXEC/MEM/WB, drives datapath strobes, handshakes with the shared memory
// port (with wait-state timeout), traps unsupported opcodes and counts
// retired instructions.
module multicycle_sequencer #(
    parameter int CNT_WIDTH  = 64,
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 WE_RF,
    output logic [1:0]           RF_din_sel,
    output logic                 ULA_din2_sel,
    output logic                 addr_sel,
    output logic                 load_pc,
    output logic                 load_ir,
    output logic                 pc_next_sel,
    output logic                 pc_adder_sel,
    output logic                 busy,
    output logic                 fault,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_LOAD    = 4'd0,
        C_STORE   = 4'd1,
        C_OP      = 4'd2,
        C_OPIMM   = 4'd3,
        C_OP32    = 4'd4,
        C_OPIMM32 = 4'd5,
        C_LUI     = 4'd6,
        C_AUIPC   = 4'd7,
        C_JAL     = 4'd8,
        C_JALR    = 4'd9,
        C_BRANCH  = 4'd10,
        C_ILLEGAL = 4'd11
    } cls_t;

    // Registered Moore control word (load_ir and the MEM load write are
    // added combinationally from mem_ready outside this word).
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       we_rf;
        logic [1:0] rf_sel;
        logic       ula_sel;
        logic       addr_sel;
        logic       load_pc;
        logic       pc_next_sel;
        logic       pc_adder_sel;
        logic       busy;
        logic       fault;
    } ctrl_t;

    localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT_W = WAIT_WIDTH'(WAIT_LIMIT);
    localparam logic                  TIMEOUT_EN   = (WAIT_LIMIT != 0);

    state_t                state_r, next_state_s;
    cls_t                  cls_r, next_cls_s;
    logic [WAIT_WIDTH-1:0] wait_r, next_wait_s, wait_inc_s;
    logic                  illegal_r, next_illegal_s;
    logic                  timeout_s;
    ctrl_t                 ctrl_r;
    logic [CNT_WIDTH-1:0]  instret_r;

    // Map the major opcode to an instruction class; anything unknown traps.
    function automatic cls_t classify(input logic [6:0] op);
        cls_t c;
        case (op)
            7'b0000011: c = C_LOAD;
            7'b0100011: c = C_STORE;
            7'b0110011: c = C_OP;
            7'b0010011: c = C_OPIMM;
            7'b0111011: c = C_OP32;
            7'b0011011: c = C_OPIMM32;
            7'b0110111: c = C_LUI;
            7'b0010111: c = C_AUIPC;
            7'b1101111: c = C_JAL;
            7'b1100111: c = C_JALR;
            7'b1100011: c = C_BRANCH;
            default:    c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    // Second ALU operand: rs2 for register-register ops and branches.
    function automatic logic uses_imm(input cls_t c);
        return !((c == C_OP) || (c == C_OP32) || (c == C_BRANCH));
    endfunction

    // Control word for a given state and instruction class.
    function automatic ctrl_t decode(input state_t st, input cls_t c);
        ctrl_t w;
        w = '0;
        case (st)
            S_IDLE: begin
                w.busy = 1'b0;
            end
            S_FETCH: begin
                w.busy     = 1'b1;
                w.mem_req  = 1'b1;
                w.addr_sel = 1'b1;
            end
            S_DECODE: begin
                w.busy = 1'b1;
            end
            S_EXEC: begin
                w.busy    = 1'b1;
                w.ula_sel = uses_imm(c);
            end
            S_MEM: begin
                w.busy    = 1'b1;
                w.mem_req = 1'b1;
                w.mem_we  = (c == C_STORE);
                w.ula_sel = 1'b1;
            end
            S_WB: begin
                w.busy         = 1'b1;
                w.load_pc      = 1'b1;
                w.ula_sel      = uses_imm(c);
                w.pc_next_sel  = (c == C_JAL) || (c == C_JALR) || (c == C_BRANCH);
                w.pc_adder_sel = (c == C_JALR);
                case (c)
                    C_OP, C_OPIMM, C_OP32, C_OPIMM32, C_LUI: begin
                        w.we_rf  = 1'b1;
                        w.rf_sel = 2'b01;
                    end
                    C_AUIPC: begin
                        w.we_rf  = 1'b1;
                        w.rf_sel = 2'b11;
                    end
                    C_JAL, C_JALR: begin
                        w.we_rf  = 1'b1;
                        w.rf_sel = 2'b10;
                    end
                    default: begin
                        w.we_rf  = 1'b0;
                        w.rf_sel = 2'b00;
                    end
                endcase
            end
            S_FAULT: begin
                w.fault = 1'b1;
            end
            default: begin
                w = '0;
            end
        endcase
        return w;
    endfunction

    assign wait_inc_s = wait_r + {{(WAIT_WIDTH-1){1'b0}}, 1'b1};
    assign timeout_s  = TIMEOUT_EN && (wait_inc_s == WAIT_LIMIT_W);

    // Next-state, class latch, wait counter and trap cause.
    always_comb begin
        next_state_s   = state_r;
        next_cls_s     = cls_r;
        next_wait_s    = wait_r;
        next_illegal_s = illegal_r;
        case (state_r)
            S_IDLE: begin
                if (run) next_state_s = S_FETCH;
                else     next_state_s = S_IDLE;
            end
            S_FETCH, S_MEM: begin
                // A ready on the last permitted wait cycle still completes.
                if (mem_ready) begin
                    next_state_s = (state_r == S_FETCH) ? S_DECODE : S_WB;
                end else if (timeout_s) begin
                    next_state_s = S_FAULT;
                end else begin
                    next_wait_s = wait_inc_s;
                end
            end
            S_DECODE: begin
                next_cls_s = classify(opcode);
                if (next_cls_s == C_ILLEGAL) begin
                    next_state_s   = S_FAULT;
                    next_illegal_s = 1'b1;
                end else begin
                    next_state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((cls_r == C_LOAD) || (cls_r == C_STORE)) next_state_s = S_MEM;
                else                                         next_state_s = S_WB;
            end
            S_WB: begin
                if (run) next_state_s = S_FETCH;
                else     next_state_s = S_IDLE;
            end
            S_FAULT: begin
                next_state_s = S_FAULT;
            end
            default: begin
                next_state_s = S_FAULT;
            end
        endcase
        if (next_state_s != state_r) next_wait_s = '0;
        else                         next_wait_s = next_wait_s;
    end

    // State register with registered control outputs decoded from next state.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            cls_r     <= C_ILLEGAL;
            wait_r    <= '0;
            illegal_r <= 1'b0;
            ctrl_r    <= '0;
            instret_r <= '0;
        end else begin
            state_r   <= next_state_s;
            cls_r     <= next_cls_s;
            wait_r    <= next_wait_s;
            illegal_r <= next_illegal_s;
            ctrl_r    <= decode(next_state_s, next_cls_s);
            if (state_r == S_WB) instret_r <= instret_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            else                 instret_r <= instret_r;
        end
    end

    assign mem_req      = ctrl_r.mem_req;
    assign mem_we       = ctrl_r.mem_we;
    assign WE_RF        = ctrl_r.we_rf | ((state_r == S_MEM) && (cls_r == C_LOAD) && mem_ready);
    assign RF_din_sel   = ctrl_r.rf_sel;
    assign ULA_din2_sel = ctrl_r.ula_sel;
    assign addr_sel     = ctrl_r.addr_sel;
    assign load_pc      = ctrl_r.load_pc;
    assign load_ir      = (state_r == S_FETCH) && mem_ready;
    assign pc_next_sel  = ctrl_r.pc_next_sel;
    assign pc_adder_sel = ctrl_r.pc_adder_sel;
    assign busy         = ctrl_r.busy;
    assign fault        = ctrl_r.fault;
    assign illegal      = illegal_r;
    assign instret      = instret_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with a short wait limit.
module tb_multicycle_sequencer;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, WE_RF, ULA_din2_sel, addr_sel, load_pc, load_ir;
    logic        pc_next_sel, pc_adder_sel, busy, fault, illegal;
    logic [1:0]  RF_din_sel;
    logic [63:0] instret;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_cnt = 64'd0;
    logic [13:0] obs;

    multicycle_sequencer #(.CNT_WIDTH(64), .WAIT_LIMIT(4), .WAIT_WIDTH(8)) dut (
        .CLK(CLK), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .WE_RF(WE_RF), .RF_din_sel(RF_din_sel),
        .ULA_din2_sel(ULA_din2_sel), .addr_sel(addr_sel), .load_pc(load_pc),
        .load_ir(load_ir), .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel),
        .busy(busy), .fault(fault), .illegal(illegal), .instret(instret)
    );

    always #5 CLK = ~CLK;

    assign obs = {mem_req, mem_we, WE_RF, RF_din_sel, ULA_din2_sel, addr_sel, load_pc,
                  load_ir, pc_next_sel, pc_adder_sel, busy, fault, illegal};

    // Pack an expected output vector in the same order as obs.
    function automatic logic [13:0] v(input logic mreq, input logic mwe, input logic we,
                                      input logic [1:0] rf, input logic ula, input logic addr,
                                      input logic lpc, input logic lir, input logic pns,
                                      input logic pas, input logic bsy, input logic flt,
                                      input logic ill);
        return {mreq, mwe, we, rf, ula, addr, lpc, lir, pns, pas, bsy, flt, ill};
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Check outputs for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [13:0] e);
        #1;
        chk(tag, {50'd0, obs}, {50'd0, e});
        @(posedge CLK);
        #1;
    endtask

    logic [13:0] V_IDLE, V_FETCH_R, V_FETCH_W, V_DEC, V_EXEC_R, V_EXEC_I;
    logic [13:0] V_MEM_LW, V_MEM_LR, V_MEM_S, V_WB_LS;

    // Four-cycle instruction with memory always ready.
    task automatic instr4(input string tag, input logic [6:0] op,
                          input logic [13:0] e_exec, input logic [13:0] e_wb);
        opcode    = op;
        mem_ready = 1'b1;
        cyc({tag, "_fetch"}, V_FETCH_R);
        cyc({tag, "_decode"}, V_DEC);
        cyc({tag, "_exec"}, e_exec);
        cyc({tag, "_wb"}, e_wb);
        exp_cnt = exp_cnt + 64'd1;
        chk({tag, "_instret"}, instret, exp_cnt);
    endtask

    initial begin
        V_IDLE    = 14'd0;
        V_FETCH_R = v(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_FETCH_W = v(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_DEC     = v(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_EXEC_R  = V_DEC;
        V_EXEC_I  = v(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_MEM_LW  = v(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_MEM_LR  = v(1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_MEM_S   = v(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        V_WB_LS   = v(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset state.
        #2;
        chk("reset_outputs", {50'd0, obs}, 64'd0);
        chk("reset_instret", instret, 64'd0);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        cyc("idle_run0", V_IDLE);
        run = 1'b1;
        cyc("idle_before_fetch", V_IDLE);

        // OP: FETCH, DECODE, EXEC, WB, back to FETCH.
        instr4("op", 7'b0110011, V_EXEC_R,
               v(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

        // LOAD with three wait states in MEM.
        opcode    = 7'b0000011;
        mem_ready = 1'b1;
        cyc("ld_fetch", V_FETCH_R);
        mem_ready = 1'b0;
        cyc("ld_decode", V_DEC);
        cyc("ld_exec", V_EXEC_I);
        cyc("ld_mem_w1", V_MEM_LW);
        cyc("ld_mem_w2", V_MEM_LW);
        cyc("ld_mem_w3", V_MEM_LW);
        mem_ready = 1'b1;
        cyc("ld_mem_ready", V_MEM_LR);
        cyc("ld_wb", V_WB_LS);
        exp_cnt = exp_cnt + 64'd1;
        chk("ld_instret", instret, exp_cnt);

        // STORE.
        opcode = 7'b0100011;
        cyc("st_fetch", V_FETCH_R);
        cyc("st_decode", V_DEC);
        cyc("st_exec", V_EXEC_I);
        cyc("st_mem", V_MEM_S);
        cyc("st_wb", V_WB_LS);
        exp_cnt = exp_cnt + 64'd1;
        chk("st_instret", instret, exp_cnt);

        // JALR, AUIPC, BRANCH write-back decodes.
        instr4("jalr", 7'b1100111, V_EXEC_I,
               v(1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        instr4("auipc", 7'b0010111, V_EXEC_I,
               v(1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        instr4("branch", 7'b1100011, V_EXEC_R,
               v(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));

        // run drops mid-instruction: OP-IMM still retires, then IDLE.
        opcode = 7'b0010011;
        cyc("opi_fetch", V_FETCH_R);
        run = 1'b0;
        cyc("opi_decode", V_DEC);
        cyc("opi_exec", V_EXEC_I);
        cyc("opi_wb", v(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_cnt = exp_cnt + 64'd1;
        cyc("opi_idle1", V_IDLE);
        cyc("opi_idle2", V_IDLE);
        chk("opi_instret", instret, exp_cnt);

        // Illegal opcode traps after DECODE and stays in FAULT.
        run    = 1'b1;
        opcode = 7'b1111111;
        cyc("ill_idle", V_IDLE);
        cyc("ill_fetch", V_FETCH_R);
        cyc("ill_decode", V_DEC);
        for (int i = 0; i < 3; i++) begin
            cyc("ill_fault", v(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
        chk("ill_instret", instret, exp_cnt);
        reset = 1'b0;
        #1;
        chk("ill_reset_outputs", {50'd0, obs}, 64'd0);
        chk("ill_reset_instret", instret, 64'd0);
        exp_cnt = 64'd0;
        @(posedge CLK);
        #1;
        reset = 1'b1;

        // FETCH timeout after four wait cycles.
        opcode    = 7'b0110011;
        mem_ready = 1'b0;
        cyc("to_idle", V_IDLE);
        for (int i = 0; i < 4; i++) begin
            cyc("to_fetch_wait", V_FETCH_W);
        end
        cyc("to_fault", v(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc("to_fault_hold", v(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        reset = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b1;

        // Ready on the fourth wait cycle wins over the timeout.
        cyc("hs_idle", V_IDLE);
        for (int i = 0; i < 3; i++) begin
            cyc("hs_fetch_wait", V_FETCH_W);
        end
        mem_ready = 1'b1;
        cyc("hs_fetch_ready", V_FETCH_R);
        mem_ready = 1'b0;
        cyc("hs_decode", V_DEC);
        cyc("hs_exec", V_EXEC_R);
        cyc("hs_wb", v(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_cnt = exp_cnt + 64'd1;
        chk("hs_instret", instret, exp_cnt);

        // Reset asserted in the middle of a LOAD's MEM phase.
        opcode    = 7'b0000011;
        mem_ready = 1'b1;
        cyc("rm_fetch", V_FETCH_R);
        mem_ready = 1'b0;
        cyc("rm_decode", V_DEC);
        cyc("rm_exec", V_EXEC_I);
        cyc("rm_mem_w1", V_MEM_LW);
        #1;
        chk("rm_mem_w2", {50'd0, obs}, {50'd0, V_MEM_LW});
        reset = 1'b0;
        #1;
        chk("rm_reset_outputs", {50'd0, obs}, 64'd0);
        chk("rm_reset_instret", instret, 64'd0);
        run = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b1;
        cyc("rm_idle1", V_IDLE);
        cyc("rm_idle2", V_IDLE);
        chk("rm_idle_busy", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
